// File: rtl/alu_issue_ctrl.sv
// Issue controller beside a single-cycle ALU: ALU results are registered with a
// 1-cycle done pulse; multiplies run on an iterative shift-add unit for WIDTH cycles.
module alu_issue_ctrl #(
    parameter int         WIDTH    = 32,
    parameter logic [2:0] MUL_CODE = 3'd6
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic [2:0]       ALUCtrl_i,
    input  logic [WIDTH-1:0] op1_i,
    input  logic [WIDTH-1:0] op2_i,
    input  logic [WIDTH-1:0] alu_result_i,
    input  logic             flush_i,
    output logic [WIDTH-1:0] result_o,
    output logic             done_o,
    output logic             stall_o,
    output logic             busy_o
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic {
        IDLE,
        MUL
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_nxt;
    logic [CNT_W-1:0] cnt;
    logic             is_mul;
    logic             accept_mul;
    logic             accept_alu;
    logic             last_iter;

    assign is_mul     = (ALUCtrl_i == MUL_CODE);
    assign accept_mul = !rst_i && (state == IDLE) && valid_i && is_mul && !flush_i;
    assign accept_alu = !rst_i && (state == IDLE) && valid_i && !is_mul && !flush_i;

    // Shift-add step; the low WIDTH bits are the same for signed and unsigned operands.
    assign acc_nxt   = mplier[0] ? (acc + mcand) : acc;
    assign last_iter = (cnt == CNT_W'(WIDTH - 1));

    // A flush releases the pipeline in the same cycle; reset forces both outputs low.
    assign stall_o = !rst_i && (accept_mul || ((state == MUL) && !flush_i));
    assign busy_o  = !rst_i && (state == MUL);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            result_o <= '0;
            done_o   <= 1'b0;
            cnt      <= '0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept_alu) begin
                        result_o <= alu_result_i;
                        done_o   <= 1'b1;
                    end else if (accept_mul) begin
                        mcand  <= op1_i;
                        mplier <= op2_i;
                        acc    <= '0;
                        cnt    <= '0;
                        state  <= MUL;
                    end
                end
                MUL: begin
                    if (flush_i) begin
                        state <= IDLE;
                    end else begin
                        acc    <= acc_nxt;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        cnt    <= cnt + 1'b1;
                        if (last_iter) begin
                            result_o <= acc_nxt;
                            done_o   <= 1'b1;
                            state    <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: ALU pass-through, iterative multiply, flush,
// back-to-back issue and reset abort, with hand-computed expectations.
module tb_alu_issue_ctrl;

    localparam int WIDTH = 32;

    logic             clk_i;
    logic             rst_i;
    logic             valid_i;
    logic [2:0]       ALUCtrl_i;
    logic [WIDTH-1:0] op1_i;
    logic [WIDTH-1:0] op2_i;
    logic [WIDTH-1:0] alu_result_i;
    logic             flush_i;
    logic [WIDTH-1:0] result_o;
    logic             done_o;
    logic             stall_o;
    logic             busy_o;

    int checks;
    int errors;

    alu_issue_ctrl #(.WIDTH(WIDTH), .MUL_CODE(3'd6)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .valid_i      (valid_i),
        .ALUCtrl_i    (ALUCtrl_i),
        .op1_i        (op1_i),
        .op2_i        (op2_i),
        .alu_result_i (alu_result_i),
        .flush_i      (flush_i),
        .result_o     (result_o),
        .done_o       (done_o),
        .stall_o      (stall_o),
        .busy_o       (busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Advance into the next cycle; inputs are driven 1 unit after the edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        valid_i      = 1'b0;
        ALUCtrl_i    = 3'd0;
        op1_i        = '0;
        op2_i        = '0;
        alu_result_i = '0;
        flush_i      = 1'b0;
    endtask

    task automatic test_reset();
        rst_i        = 1'b1;
        valid_i      = 1'b1;
        ALUCtrl_i    = 3'd6;
        op1_i        = 32'd3;
        op2_i        = 32'd4;
        flush_i      = 1'b1;
        step();
        step();
        #1;
        checks++;
        if (stall_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_stall_busy: stall=%b busy=%b expected 0 0", stall_o, busy_o);
        end
        checks++;
        if (done_o !== 1'b0 || result_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: done=%b result=%h expected 0 00000000", done_o, result_o);
        end
        rst_i = 1'b0;
        idle_inputs();
        step();
    endtask

    task automatic test_alu_op();
        valid_i      = 1'b1;
        ALUCtrl_i    = 3'd4;
        alu_result_i = 32'h0000_0009;
        #1;
        checks++;
        if (stall_o !== 1'b0) begin
            errors++;
            $display("FAIL alu_stall_accept: stall=%b expected 0", stall_o);
        end
        step();
        idle_inputs();
        #1;
        checks++;
        if (done_o !== 1'b1 || result_o !== 32'h9 || stall_o !== 1'b0) begin
            errors++;
            $display("FAIL alu_done: done=%b result=%h stall=%b expected 1 00000009 0",
                     done_o, result_o, stall_o);
        end
        step();
        #1;
        checks++;
        if (done_o !== 1'b0 || result_o !== 32'h9) begin
            errors++;
            $display("FAIL alu_hold: done=%b result=%h expected 0 00000009", done_o, result_o);
        end
    endtask

    // Code 0 and code 7 take the single-cycle path, issued back to back.
    task automatic test_other_codes();
        valid_i      = 1'b1;
        ALUCtrl_i    = 3'd0;
        alu_result_i = 32'h0000_0055;
        step();
        ALUCtrl_i    = 3'd7;
        alu_result_i = 32'h0000_00AA;
        #1;
        checks++;
        if (done_o !== 1'b1 || result_o !== 32'h55 || stall_o !== 1'b0) begin
            errors++;
            $display("FAIL code0: done=%b result=%h stall=%b expected 1 00000055 0",
                     done_o, result_o, stall_o);
        end
        step();
        idle_inputs();
        #1;
        checks++;
        if (done_o !== 1'b1 || result_o !== 32'hAA || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL code7: done=%b result=%h busy=%b expected 1 000000aa 0",
                     done_o, result_o, busy_o);
        end
        step();
    endtask

    task automatic test_mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic [WIDTH-1:0] exp);
        int bad;
        valid_i   = 1'b1;
        ALUCtrl_i = 3'd6;
        op1_i     = a;
        op2_i     = b;
        #1;
        checks++;
        if (stall_o !== 1'b1) begin
            errors++;
            $display("FAIL mul_stall_accept: stall=%b expected 1", stall_o);
        end
        step();
        idle_inputs();
        bad = 0;
        for (int i = 1; i <= WIDTH; i++) begin
            #1;
            if (stall_o !== 1'b1 || busy_o !== 1'b1 || done_o !== 1'b0) begin
                if (bad == 0)
                    $display("FAIL mul_running cyc%0d: stall=%b busy=%b done=%b expected 1 1 0",
                             i, stall_o, busy_o, done_o);
                bad++;
            end
            step();
        end
        checks++;
        if (bad != 0) errors++;
        #1;
        checks++;
        if (done_o !== 1'b1 || result_o !== exp || stall_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL mul_done %h*%h: done=%b result=%h stall=%b busy=%b expected 1 %h 0 0",
                     a, b, done_o, result_o, stall_o, busy_o, exp);
        end
        step();
        #1;
        checks++;
        if (done_o !== 1'b0 || result_o !== exp) begin
            errors++;
            $display("FAIL mul_after: done=%b result=%h expected 0 %h", done_o, result_o, exp);
        end
    endtask

    task automatic test_flush_idle();
        valid_i   = 1'b1;
        ALUCtrl_i = 3'd6;
        op1_i     = 32'd2;
        op2_i     = 32'd2;
        flush_i   = 1'b1;
        #1;
        checks++;
        if (stall_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle_stall: stall=%b expected 0", stall_o);
        end
        step();
        idle_inputs();
        #1;
        checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle_next: busy=%b done=%b expected 0 0", busy_o, done_o);
        end
        step();
    endtask

    task automatic test_flush_mul();
        valid_i      = 1'b1;
        ALUCtrl_i    = 3'd2;
        alu_result_i = 32'h0000_CAFE;
        step();
        ALUCtrl_i = 3'd6;
        op1_i     = 32'd5;
        op2_i     = 32'd5;
        step();
        idle_inputs();
        for (int i = 1; i < 10; i++) step();
        flush_i = 1'b1;
        #1;
        checks++;
        if (stall_o !== 1'b0 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL flush_mul_cycle: stall=%b busy=%b expected 0 1", stall_o, busy_o);
        end
        step();
        flush_i = 1'b0;
        #1;
        checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || result_o !== 32'hCAFE) begin
            errors++;
            $display("FAIL flush_mul_next: busy=%b done=%b result=%h expected 0 0 0000cafe",
                     busy_o, done_o, result_o);
        end
        valid_i      = 1'b1;
        ALUCtrl_i    = 3'd0;
        alu_result_i = 32'h0000_1234;
        step();
        idle_inputs();
        #1;
        checks++;
        if (done_o !== 1'b1 || result_o !== 32'h1234) begin
            errors++;
            $display("FAIL flush_then_add: done=%b result=%h expected 1 00001234", done_o, result_o);
        end
        step();
    endtask

    task automatic test_back_to_back();
        int bad;
        valid_i   = 1'b1;
        ALUCtrl_i = 3'd6;
        op1_i     = 32'd2;
        op2_i     = 32'd3;
        step();
        // Noise on valid/ALUCtrl/operands during MUL must be ignored.
        for (int i = 1; i <= WIDTH; i++) begin
            valid_i      = i[0];
            ALUCtrl_i    = i[0] ? 3'd6 : 3'd1;
            op1_i        = 32'hDEAD_0000 + 32'(i);
            op2_i        = 32'h0000_BEEF;
            alu_result_i = 32'hFFFF_0000;
            step();
        end
        valid_i   = 1'b1;
        ALUCtrl_i = 3'd6;
        op1_i     = 32'd3;
        op2_i     = 32'd5;
        #1;
        checks++;
        if (done_o !== 1'b1 || result_o !== 32'd6 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first_done: done=%b result=%h busy=%b expected 1 00000006 0",
                     done_o, result_o, busy_o);
        end
        step();
        bad = 0;
        for (int i = 1; i <= WIDTH; i++) begin
            valid_i   = ~i[0];
            ALUCtrl_i = 3'd3;
            #1;
            if (busy_o !== 1'b1 || done_o !== 1'b0) begin
                if (bad == 0)
                    $display("FAIL b2b_running cyc%0d: busy=%b done=%b expected 1 0", i, busy_o, done_o);
                bad++;
            end
            step();
        end
        checks++;
        if (bad != 0) errors++;
        idle_inputs();
        #1;
        checks++;
        if (done_o !== 1'b1 || result_o !== 32'd15) begin
            errors++;
            $display("FAIL b2b_second_done: done=%b result=%h expected 1 0000000f", done_o, result_o);
        end
        step();
    endtask

    task automatic test_reset_mid_mul();
        int bad;
        valid_i   = 1'b1;
        ALUCtrl_i = 3'd6;
        op1_i     = 32'd9;
        op2_i     = 32'd9;
        step();
        idle_inputs();
        for (int i = 1; i < 5; i++) step();
        rst_i = 1'b1;
        #1;
        checks++;
        if (busy_o !== 1'b0 || stall_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_during: busy=%b stall=%b expected 0 0", busy_o, stall_o);
        end
        step();
        rst_i = 1'b0;
        #1;
        checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || result_o !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid_next: busy=%b done=%b result=%h expected 0 0 00000000",
                     busy_o, done_o, result_o);
        end
        bad = 0;
        for (int i = 0; i < WIDTH + 8; i++) begin
            step();
            #1;
            if (done_o !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL rst_mid_no_done: done pulses=%0d expected 0", bad);
        end
        // Accept in the very first cycle after reset is released.
        rst_i = 1'b1;
        step();
        rst_i        = 1'b0;
        valid_i      = 1'b1;
        ALUCtrl_i    = 3'd1;
        alu_result_i = 32'h0000_0077;
        step();
        idle_inputs();
        #1;
        checks++;
        if (done_o !== 1'b1 || result_o !== 32'h77) begin
            errors++;
            $display("FAIL rst_release_accept: done=%b result=%h expected 1 00000077", done_o, result_o);
        end
        step();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_i  = 1'b1;
        idle_inputs();
        test_reset();
        test_alu_op();
        test_other_codes();
        test_mul(32'd7, 32'd6, 32'd42);
        test_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
        test_mul(32'h8000_0000, 32'd2, 32'h0000_0000);
        test_flush_idle();
        test_flush_mul();
        test_back_to_back();
        test_reset_mid_mul();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 Parameter WIDTH, default 32: operand/result width in bits.
REQ-002 Parameter MUL_CODE, default 3'd6: ALUCtrl code that selects multiply.
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 rst_i  input  1  reset, synchronous, active-high.
REQ-005 valid_i  input  1  an operation is presented this cycle.
REQ-006 ALUCtrl_i  input  3  operation code from ALU_Control.
REQ-007 op1_i  input  WIDTH  first operand (rs1 data).
REQ-008 op2_i  input  WIDTH  second operand (rs2 or immediate).
REQ-009 alu_result_i  input  WIDTH  result from the single-cycle combinational ALU for the presented operation.
REQ-010 flush_i  input  1  abort any in-flight operation.
REQ-011 result_o  output  WIDTH  registered result.
REQ-012 done_o  output  1  one-cycle pulse; result_o valid this cycle.
REQ-013 stall_o  output  1  pipeline must hold its current instruction.
REQ-014 busy_o  output  1  multiply in progress.

Function
REQ-015 States: IDLE, MUL; no other states.
REQ-016 IDLE, valid_i=1, ALUCtrl_i!=MUL_CODE, flush_i=0: next edge result_o<=alu_result_i, done_o<=1; state stays IDLE; latency 1.
REQ-017 Non-multiply codes, including 0 and undefined codes, SHALL take the REQ-016 path unchanged.
REQ-018 IDLE, valid_i=1, ALUCtrl_i==MUL_CODE, flush_i=0: next edge capture op1_i into multiplicand, op2_i into multiplier, clear accumulator and iteration counter, enter MUL.
REQ-019 Each MUL cycle: if multiplier[0]=1, accumulator += multiplicand (mod 2^WIDTH); multiplicand <<= 1; multiplier >>= 1; counter += 1.
REQ-020 Exactly WIDTH iterations, no early termination; on the edge completing iteration WIDTH, result_o<=final accumulator, done_o<=1, state<=IDLE.
REQ-021 Multiply latency: done_o high exactly WIDTH+1 cycles after the accept cycle; result = low WIDTH bits of op1*op2 (identical for signed and unsigned).
REQ-022 stall_o = (IDLE and valid_i and ALUCtrl_i==MUL_CODE and not flush_i) or (MUL and not flush_i) -- combinational; deasserted in the cycle done_o is high.
REQ-023 busy_o = 1 exactly when state is MUL.
REQ-024 valid_i and ALUCtrl_i SHALL be ignored while in MUL.
REQ-025 Back-to-back: the cycle done_o is high the block is in IDLE and SHALL accept a new valid_i.
REQ-026 done_o SHALL be 0 in every cycle not specified by REQ-016/REQ-020.
REQ-027 result_o SHALL hold its last value when done_o=0.
REQ-028 flush_i=1 in IDLE: operation not accepted, no done_o next cycle.
REQ-029 flush_i=1 in MUL: next edge state<=IDLE, no done_o, result_o unchanged.
REQ-030 Counter width SHALL be ceil(log2(WIDTH))+1 bits; no wrap before completion.

Reset
REQ-031 rst_i=1 at an edge: state<=IDLE, result_o<=0, done_o<=0, counter, accumulator, multiplicand, multiplier <=0.
REQ-032 While rst_i=1: stall_o=0, busy_o=0; rst_i overrides valid_i and flush_i.
REQ-033 Reset mid-multiply SHALL abort it with no done_o; first valid_i accepted in the cycle after rst_i falls.

Verification
REQ-034 ALUCtrl_i=4, alu_result_i=0x0000_0009, valid_i 1 cycle -> next cycle done_o=1, result_o=0x9, stall_o never 1.
REQ-035 ALUCtrl_i=6, op1=7, op2=6 -> stall_o high 33 cycles (accept+32), done_o at cycle 33, result_o=42.
REQ-036 ALUCtrl_i=6, op1=0xFFFF_FFFF, op2=0xFFFF_FFFF -> result_o=0x0000_0001 after 33 cycles; op1=0x8000_0000, op2=2 -> 0x0.
REQ-037 mul accepted, flush_i at 10th MUL cycle -> busy_o=0 next cycle, no done_o, result_o unchanged; then add accepted -> done_o next cycle.
REQ-038 mul completes, new mul (op1=3, op2=5) presented in done_o cycle -> accepted, second done_o 33 cycles later, result_o=15; valid_i toggled during MUL ignored.
REQ-039 rst_i asserted at 5th MUL cycle -> next cycle busy_o=0, done_o=0, result_o=0; no done_o afterward.
